trap_unit: RTL and testbench

Machine-mode trap sequencer that drives the exception-write side of the CSR file. It detects synchronous exceptions, enabled interrupts and `mret` at the retiring instruction. It then produces the `mcause`/`mepc`/`mtval`/`mstatus` update with its one-cycle write strobe, and redirects the fetch PC to `mtvec` or `mepc` while flushing the pipeline.

---
 rtl/trap_unit.sv | 186 ++++++++++++++++++
 tb/tb_trap_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_unit.sv
// ============================================================================
//  Module   : trap_unit
//  Purpose  : Machine-mode trap sequencer: exception/interrupt/mret capture,
//             CSR exception-write strobe and fetch redirect with flush.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] fetch_addr_i,
    input  logic [31:0] mem_addr_i,
    input  logic        inst_misaligned_i,
    input  logic        illegal_inst_i,
    input  logic        ebreak_i,
    input  logic        ecall_i,
    input  logic        load_misaligned_i,
    input  logic        store_misaligned_i,
    input  logic        mret_i,
    input  logic        sw_irq_i,
    input  logic        timer_irq_i,
    input  logic        ext_irq_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mcause_i,
    output logic        we_exc_o,
    output logic [31:0] mcause_d_o,
    output logic [31:0] mepc_d_o,
    output logic [31:0] mtval_d_o,
    output logic [31:0] mstatus_d_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] pc_target_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TRAP     = 2'd1,
        S_MRET     = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_take_trap;
    logic        w_take_mret;
    logic [31:0] w_cause;
    logic [31:0] w_mtval;
    logic [31:0] w_trap_mstatus;
    logic [31:0] w_mret_mstatus;
    logic [31:0] w_tvec_base;
    logic [31:0] w_trap_target;
    logic        w_unused_ok;

    logic [31:0] r_mcause;
    logic [31:0] r_mepc;
    logic [31:0] r_mtval;
    logic [31:0] r_mstatus;
    logic [31:0] r_target;

    // Cause selection: first match wins, interrupts ahead of exceptions ahead of mret.
    always_comb begin
        w_take_trap = 1'b0;
        w_cause     = 32'd0;
        w_mtval     = 32'd0;
        if (valid_i) begin
            w_take_trap = 1'b1;
            if (ext_irq_i && mie_i[11] && mstatus_i[3]) begin
                w_cause = 32'h8000_000B;
            end else if (sw_irq_i && mie_i[3] && mstatus_i[3]) begin
                w_cause = 32'h8000_0003;
            end else if (timer_irq_i && mie_i[7] && mstatus_i[3]) begin
                w_cause = 32'h8000_0007;
            end else if (inst_misaligned_i) begin
                w_cause = 32'd0;
                w_mtval = fetch_addr_i;
            end else if (illegal_inst_i) begin
                w_cause = 32'd2;
                w_mtval = inst_i;
            end else if (ebreak_i) begin
                w_cause = 32'd3;
                w_mtval = pc_i;
            end else if (ecall_i) begin
                w_cause = 32'd11;
            end else if (load_misaligned_i) begin
                w_cause = 32'd4;
                w_mtval = mem_addr_i;
            end else if (store_misaligned_i) begin
                w_cause = 32'd6;
                w_mtval = mem_addr_i;
            end else begin
                w_take_trap = 1'b0;
            end
        end
    end

    assign w_take_mret = valid_i && mret_i && !w_take_trap;

    assign w_trap_mstatus = {mstatus_i[31:13], 2'b11, mstatus_i[10:8],
                             mstatus_i[3], mstatus_i[6:4], 1'b0, mstatus_i[2:0]};
    assign w_mret_mstatus = {mstatus_i[31:13], 2'b11, mstatus_i[10:8],
                             1'b1, mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};

    // Vectored mode applies only to interrupts; modes 10/11 fall back to direct.
    assign w_tvec_base   = {mtvec_i[31:2], 2'b00};
    assign w_trap_target = (mtvec_i[1:0] == 2'b01 && r_mcause[31])
                         ? w_tvec_base + {25'd0, r_mcause[4:0], 2'b00}
                         : w_tvec_base;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take_trap) begin
                    w_state_nxt = S_TRAP;
                end else if (w_take_mret) begin
                    w_state_nxt = S_MRET;
                end
            end
            S_TRAP:     w_state_nxt = S_REDIRECT;
            S_MRET:     w_state_nxt = S_REDIRECT;
            S_REDIRECT: w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mcause  <= 32'd0;
            r_mepc    <= 32'd0;
            r_mtval   <= 32'd0;
            r_mstatus <= 32'd0;
        end else if (r_state == S_IDLE && w_take_trap) begin
            r_mcause  <= w_cause;
            r_mepc    <= pc_i;
            r_mtval   <= w_mtval;
            r_mstatus <= w_trap_mstatus;
        end else if (r_state == S_IDLE && w_take_mret) begin
            r_mcause  <= mcause_i;
            r_mepc    <= mepc_i;
            r_mtval   <= 32'd0;
            r_mstatus <= w_mret_mstatus;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_target <= 32'd0;
        end else if (r_state == S_TRAP) begin
            r_target <= w_trap_target;
        end else if (r_state == S_MRET) begin
            r_target <= {mepc_i[31:2], 2'b00};
        end
    end

    assign we_exc_o    = (r_state == S_TRAP) || (r_state == S_MRET);
    assign stall_o     = (r_state != S_IDLE);
    assign redirect_o  = (r_state == S_REDIRECT);
    assign flush_o     = (r_state == S_REDIRECT);
    assign mcause_d_o  = r_mcause;
    assign mepc_d_o    = r_mepc;
    assign mtval_d_o   = r_mtval;
    assign mstatus_d_o = r_mstatus;
    assign pc_target_o = r_target;

    assign w_unused_ok = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

endmodule

`default_nettype wire

// File: tb/tb_trap_unit.sv
// ============================================================================
//  Module   : tb_trap_unit
//  Purpose  : Self-checking bench for trap_unit: directed cases plus random
//             events compared against a behavioural trap model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] pc_i, inst_i, fetch_addr_i, mem_addr_i;
    logic        inst_misaligned_i, illegal_inst_i, ebreak_i, ecall_i;
    logic        load_misaligned_i, store_misaligned_i, mret_i;
    logic        sw_irq_i, timer_irq_i, ext_irq_i;
    logic [31:0] mstatus_i, mie_i, mtvec_i, mepc_i, mcause_i;
    logic        we_exc_o, stall_o, flush_o, redirect_o;
    logic [31:0] mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, pc_target_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_mcause = 32'd0, exp_mepc = 32'd0, exp_mtval = 32'd0;
    logic [31:0] exp_mstatus = 32'd0, exp_target = 32'd0;

    trap_unit u_dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .valid_i            (valid_i),
        .pc_i               (pc_i),
        .inst_i             (inst_i),
        .fetch_addr_i       (fetch_addr_i),
        .mem_addr_i         (mem_addr_i),
        .inst_misaligned_i  (inst_misaligned_i),
        .illegal_inst_i     (illegal_inst_i),
        .ebreak_i           (ebreak_i),
        .ecall_i            (ecall_i),
        .load_misaligned_i  (load_misaligned_i),
        .store_misaligned_i (store_misaligned_i),
        .mret_i             (mret_i),
        .sw_irq_i           (sw_irq_i),
        .timer_irq_i        (timer_irq_i),
        .ext_irq_i          (ext_irq_i),
        .mstatus_i          (mstatus_i),
        .mie_i              (mie_i),
        .mtvec_i            (mtvec_i),
        .mepc_i             (mepc_i),
        .mcause_i           (mcause_i),
        .we_exc_o           (we_exc_o),
        .mcause_d_o         (mcause_d_o),
        .mepc_d_o           (mepc_d_o),
        .mtval_d_o          (mtval_d_o),
        .mstatus_d_o        (mstatus_d_o),
        .stall_o            (stall_o),
        .flush_o            (flush_o),
        .redirect_o         (redirect_o),
        .pc_target_o        (pc_target_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        valid_i = 1'b0; pc_i = '0; inst_i = '0; fetch_addr_i = '0; mem_addr_i = '0;
        inst_misaligned_i = 1'b0; illegal_inst_i = 1'b0; ebreak_i = 1'b0; ecall_i = 1'b0;
        load_misaligned_i = 1'b0; store_misaligned_i = 1'b0; mret_i = 1'b0;
        sw_irq_i = 1'b0; timer_irq_i = 1'b0; ext_irq_i = 1'b0;
        mstatus_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0; mcause_i = '0;
    endtask

    task automatic rand_inputs();
        valid_i            = ($urandom_range(0, 3) != 0);
        pc_i               = $urandom;
        inst_i             = $urandom;
        fetch_addr_i       = $urandom;
        mem_addr_i         = $urandom;
        inst_misaligned_i  = ($urandom_range(0, 7) == 0);
        illegal_inst_i     = ($urandom_range(0, 7) == 0);
        ebreak_i           = ($urandom_range(0, 7) == 0);
        ecall_i            = ($urandom_range(0, 7) == 0);
        load_misaligned_i  = ($urandom_range(0, 7) == 0);
        store_misaligned_i = ($urandom_range(0, 7) == 0);
        mret_i             = ($urandom_range(0, 3) == 0);
        sw_irq_i           = ($urandom_range(0, 3) == 0);
        timer_irq_i        = ($urandom_range(0, 3) == 0);
        ext_irq_i          = ($urandom_range(0, 3) == 0);
        mstatus_i          = $urandom;
        mie_i              = $urandom;
        mtvec_i            = $urandom;
        mepc_i             = $urandom;
        mcause_i           = $urandom;
    endtask

    // Reference: kind 0 = nothing, 1 = trap, 2 = mret. Priority follows table order.
    function automatic void model(output int kind, output logic [31:0] cause,
                                  output logic [31:0] tval);
        logic        irq_req [3];
        int          irq_bit [3];
        logic [31:0] irq_code[3];
        logic        exc_req [6];
        logic [31:0] exc_code[6];
        logic [31:0] exc_tval[6];
        irq_req  = '{ext_irq_i, sw_irq_i, timer_irq_i};
        irq_bit  = '{11, 3, 7};
        irq_code = '{32'h8000_000B, 32'h8000_0003, 32'h8000_0007};
        exc_req  = '{inst_misaligned_i, illegal_inst_i, ebreak_i, ecall_i,
                     load_misaligned_i, store_misaligned_i};
        exc_code = '{32'd0, 32'd2, 32'd3, 32'd11, 32'd4, 32'd6};
        exc_tval = '{fetch_addr_i, inst_i, pc_i, 32'd0, mem_addr_i, mem_addr_i};
        kind  = 0;
        cause = 32'd0;
        tval  = 32'd0;
        if (!valid_i) return;
        for (int i = 0; i < 3; i++) begin
            if (irq_req[i] && mie_i[irq_bit[i]] && mstatus_i[3]) begin
                kind = 1; cause = irq_code[i]; tval = 32'd0;
                return;
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (exc_req[i]) begin
                kind = 1; cause = exc_code[i]; tval = exc_tval[i];
                return;
            end
        end
        if (mret_i) kind = 2;
    endfunction

    task automatic check_data(input string tag);
        check({tag, ".mcause"},  mcause_d_o,  exp_mcause);
        check({tag, ".mepc"},    mepc_d_o,    exp_mepc);
        check({tag, ".mtval"},   mtval_d_o,   exp_mtval);
        check({tag, ".mstatus"}, mstatus_d_o, exp_mstatus);
    endtask

    // Inputs for the sampling cycle must already be driven. When scramble is set,
    // everything is randomized while the FSM is busy (causes must be ignored).
    task automatic run_txn(input string tag, input bit scramble);
        int          kind;
        logic [31:0] cause, tval;
        model(kind, cause, tval);
        if (kind == 1) begin
            exp_mcause  = cause;
            exp_mepc    = pc_i;
            exp_mtval   = tval;
            exp_mstatus = (mstatus_i & ~32'h0000_1888) | 32'h0000_1800
                        | (mstatus_i[3] ? 32'h80 : 32'h0);
        end else if (kind == 2) begin
            exp_mcause  = mcause_i;
            exp_mepc    = mepc_i;
            exp_mtval   = 32'd0;
            exp_mstatus = (mstatus_i & ~32'h0000_1888) | 32'h0000_1880
                        | (mstatus_i[7] ? 32'h8 : 32'h0);
        end
        tick();
        if (kind == 0) begin
            check({tag, ".idle_we"},    32'(we_exc_o),   32'd0);
            check({tag, ".idle_stall"}, 32'(stall_o),    32'd0);
            check({tag, ".idle_redir"}, 32'(redirect_o), 32'd0);
            check_data({tag, ".hold"});
            return;
        end
        check({tag, ".we"},    32'(we_exc_o),   32'd1);
        check({tag, ".stall"}, 32'(stall_o),    32'd1);
        check({tag, ".redir"}, 32'(redirect_o | flush_o), 32'd0);
        check_data(tag);
        if (scramble) rand_inputs();
        if (kind == 2) begin
            exp_target = mepc_i & ~32'd3;
        end else if (mtvec_i[1:0] == 2'b01 && exp_mcause[31]) begin
            exp_target = (mtvec_i & ~32'd3) + 32'd4 * (exp_mcause & 32'd31);
        end else begin
            exp_target = mtvec_i & ~32'd3;
        end
        tick();
        check({tag, ".r_redirect"}, 32'(redirect_o), 32'd1);
        check({tag, ".r_flush"},    32'(flush_o),    32'd1);
        check({tag, ".r_stall"},    32'(stall_o),    32'd1);
        check({tag, ".r_we"},       32'(we_exc_o),   32'd0);
        check({tag, ".target"},     pc_target_o,     exp_target);
        if (scramble) rand_inputs();
        tick();
        check({tag, ".end_strobes"},
              32'({we_exc_o, stall_o, flush_o, redirect_o}), 32'd0);
        check_data({tag, ".end"});
    endtask

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        check("reset.strobes", 32'({we_exc_o, stall_o, flush_o, redirect_o}), 32'd0);
        check("reset.target", pc_target_o, 32'd0);
        check_data("reset");

        // Illegal instruction, direct mode
        clear_inputs();
        valid_i = 1'b1; pc_i = 32'h100; inst_i = 32'hFFFF_FFFF; illegal_inst_i = 1'b1;
        mtvec_i = 32'h200; mstatus_i = 32'h8;
        run_txn("illegal", 1'b0);
        check("illegal.lit_mcause", mcause_d_o, 32'd2);
        check("illegal.lit_mstatus", mstatus_d_o, 32'h1880);
        check("illegal.lit_mtval", mtval_d_o, 32'hFFFF_FFFF);
        check("illegal.lit_target", pc_target_o, 32'h200);

        // Timer interrupt, vectored
        clear_inputs();
        valid_i = 1'b1; mtvec_i = 32'h401; mie_i = 32'h80; mstatus_i = 32'h8;
        timer_irq_i = 1'b1; pc_i = 32'h40;
        run_txn("timer", 1'b0);
        check("timer.lit_mcause", mcause_d_o, 32'h8000_0007);
        check("timer.lit_mepc", mepc_d_o, 32'h40);
        check("timer.lit_target", pc_target_o, 32'h41C);

        // Interrupt with MIE clear is not taken
        clear_inputs();
        valid_i = 1'b1; ext_irq_i = 1'b1; mie_i = 32'h800;
        run_txn("mie0", 1'b0);
        tick();
        check("mie0.stall2", 32'(stall_o), 32'd0);

        // MRET
        clear_inputs();
        valid_i = 1'b1; mret_i = 1'b1; mepc_i = 32'h124; mcause_i = 32'd11;
        mstatus_i = 32'h1880;
        run_txn("mret", 1'b0);
        check("mret.lit_mstatus", mstatus_d_o, 32'h1888);
        check("mret.lit_target", pc_target_o, 32'h124);

        // Priority A / B
        clear_inputs();
        valid_i = 1'b1; ecall_i = 1'b1; load_misaligned_i = 1'b1; mret_i = 1'b1;
        pc_i = 32'h300; mem_addr_i = 32'h1235;
        run_txn("prioA", 1'b0);
        check("prioA.lit_mcause", mcause_d_o, 32'd11);
        clear_inputs();
        valid_i = 1'b1; ecall_i = 1'b1; load_misaligned_i = 1'b1; mret_i = 1'b1;
        sw_irq_i = 1'b1; mie_i = 32'h8; mstatus_i = 32'h8; pc_i = 32'h304;
        run_txn("prioB", 1'b0);
        check("prioB.lit_mcause", mcause_d_o, 32'h8000_0003);
        check("prioB.lit_mepc", mepc_d_o, 32'h304);

        // Reset while in TRAP
        clear_inputs();
        valid_i = 1'b1; illegal_inst_i = 1'b1; pc_i = 32'h500; mtvec_i = 32'h600;
        tick();
        check("rst_mid.in_trap", 32'(we_exc_o), 32'd1);
        clear_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_mcause = '0; exp_mepc = '0; exp_mtval = '0; exp_mstatus = '0; exp_target = '0;
        check("rst_mid.strobes", 32'({we_exc_o, stall_o, flush_o, redirect_o}), 32'd0);
        check("rst_mid.target", pc_target_o, 32'd0);
        check_data("rst_mid");
        tick();
        check("rst_mid.no_redirect", 32'({we_exc_o, redirect_o}), 32'd0);

        // Random back-to-back traffic
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            run_txn("rand", 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
